// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions used by the result-capture buffer.
package tinyalu_pkg;

  localparam int ALU_RESULT_W     = 16;
  localparam int ALU_SEQ_W        = 8;
  localparam int ALU_CAP_MAX_CONS = 8;

  // One buffered capture at the default widths: sequence tag above the result.
  typedef struct packed {
    logic [ALU_SEQ_W-1:0]    seq;
    logic [ALU_RESULT_W-1:0] result;
  } alu_cap_t;

endpackage

// File: rtl/alu_result_rdport.sv
// One consumer read port of the broadcast capture FIFO: owns its read pointer,
// computes its occupancy and handles valid/ready popping and enable tracking.
module alu_result_rdport #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cons_en,
  input  logic             out_ready,
  input  logic [PTR_W-1:0] wp_q,
  input  logic [PTR_W-1:0] wp_d,
  output logic [PTR_W-2:0] rd_addr,
  output logic [PTR_W-1:0] cnt,
  output logic             out_valid
);

  logic [PTR_W-1:0] rp_q;
  logic [PTR_W-1:0] rp_d;
  logic             pop;

  // Occupancy, head valid and next read pointer; a disabled port shadows the
  // write pointer so that on re-enable it only sees later captures.
  always_comb begin
    cnt       = wp_q - rp_q;
    out_valid = cons_en && (cnt != '0);
    pop       = out_valid && out_ready;
    rd_addr   = rp_q[PTR_W-2:0];
    rp_d      = rp_q;
    if (!cons_en) begin
      rp_d = wp_d;
    end else if (pop) begin
      rp_d = rp_q + PTR_W'(1);
    end
  end

  // Read pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp_q <= '0;
    end else begin
      rp_q <= rp_d;
    end
  end

endmodule

// File: rtl/alu_result_capture.sv
// Captures TinyALU results on each done strobe, tags them with a sequence
// number and broadcasts them to several independent valid/ready consumers.
module alu_result_capture
  import tinyalu_pkg::*;
#(
  parameter int RESULT_W = ALU_RESULT_W,
  parameter int DEPTH    = 8,
  parameter int NUM_CONS = 2,
  parameter int SEQ_W    = ALU_SEQ_W,
  parameter int DROP_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         done,
  input  logic [RESULT_W-1:0]          result,
  input  logic [NUM_CONS-1:0]          cons_en,
  output logic [NUM_CONS-1:0]          out_valid,
  input  logic [NUM_CONS-1:0]          out_ready,
  output logic [NUM_CONS*RESULT_W-1:0] out_result,
  output logic [NUM_CONS*SEQ_W-1:0]    out_seq,
  input  logic                         clr_err,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_cnt,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [SEQ_W+RESULT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]  level_d;
  logic              full;
  logic              capture;
  logic              drop;

  logic [PTR_W-1:0]  cnt     [NUM_CONS];
  logic [AW-1:0]     rd_addr [NUM_CONS];

  // Full/level reduction over enabled consumers from registered pointers, then
  // capture/drop decisions; a clear overrides a same-cycle drop.
  always_comb begin
    full    = 1'b0;
    level_d = '0;
    for (int i = 0; i < NUM_CONS; i++) begin
      if (cons_en[i]) begin
        if (cnt[i] == PTR_W'(DEPTH)) full = 1'b1;
        if (cnt[i] > level_d) level_d = cnt[i];
      end
    end
    capture    = done && !full;
    drop       = done && full;
    wp_d       = wp_q + PTR_W'(capture);
    seq_d      = seq_q + SEQ_W'(capture);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_err) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Write pointer, sequence tag and error state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wp_q       <= wp_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Capture storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (capture) mem[wp_q[AW-1:0]] <= {seq_q, result};
  end

  for (genvar g = 0; g < NUM_CONS; g++) begin : g_port
    alu_result_rdport #(
      .PTR_W (PTR_W)
    ) u_rdport (
      .clk       (clk),
      .reset_n   (reset_n),
      .cons_en   (cons_en[g]),
      .out_ready (out_ready[g]),
      .wp_q      (wp_q),
      .wp_d      (wp_d),
      .rd_addr   (rd_addr[g]),
      .cnt       (cnt[g]),
      .out_valid (out_valid[g])
    );

    assign out_result[g*RESULT_W +: RESULT_W] = mem[rd_addr[g]][RESULT_W-1:0];
    assign out_seq[g*SEQ_W +: SEQ_W]          = mem[rd_addr[g]][SEQ_W+RESULT_W-1:RESULT_W];
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign level    = level_d;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed self-checking bench for alu_result_capture at default parameters.
module tb_alu_result_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        done;
  logic [15:0] result;
  logic [1:0]  cons_en;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [31:0] out_result;
  logic [15:0] out_seq;
  logic        clr_err;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;

  alu_result_capture #(
    .RESULT_W (16),
    .DEPTH    (8),
    .NUM_CONS (2),
    .SEQ_W    (8),
    .DROP_W   (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .result     (result),
    .cons_en    (cons_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_seq    (out_seq),
    .clr_err    (clr_err),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;

    reset_n = 1'b0; done = 1'b0; result = '0; cons_en = 2'b11;
    out_ready = 2'b11; clr_err = 1'b0;
    #12;
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'h0);
    @(negedge clk); reset_n = 1'b1;
    applyStimulus();

    // Three back-to-back captures, both consumers ready.
    for (int k = 0; k < 3; k++) begin
      done = 1'b1; result = vals[k];
      applyStimulus();
      checkOutput("burst_valid", 32'(out_valid), 32'h3);
      checkOutput("burst_res0", 32'(out_result[15:0]), 32'(vals[k]));
      checkOutput("burst_res1", 32'(out_result[31:16]), 32'(vals[k]));
      checkOutput("burst_seq0", 32'(out_seq[7:0]), 32'(k));
      checkOutput("burst_seq1", 32'(out_seq[15:8]), 32'(k));
    end
    done = 1'b0;
    applyStimulus();
    checkOutput("burst_empty", 32'(out_valid), 32'h0);

    // Consumer 1 stalled: 10 captures, 8 buffered (seq 3..10), 2 dropped.
    out_ready = 2'b01;
    for (int k = 0; k < 10; k++) begin
      done = 1'b1; result = 16'h0100 + 16'(k);
      applyStimulus();
    end
    done = 1'b0;
    checkOutput("ovf_drop", 32'(drop_cnt), 32'd2);
    checkOutput("ovf_flag", 32'(overflow), 32'h1);
    checkOutput("ovf_level", 32'(level), 32'd8);
    checkOutput("ovf_valid", 32'(out_valid), 32'h2);
    out_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      checkOutput("ovf_drain_seq", 32'(out_seq[15:8]), 32'(3 + k));
      checkOutput("ovf_drain_res", 32'(out_result[31:16]), 32'h0100 + 32'(k));
      applyStimulus();
    end
    checkOutput("ovf_drained", 32'(out_valid), 32'h0);
    checkOutput("ovf_lvl0", 32'(level), 32'h0);
    clr_err = 1'b1;
    applyStimulus();
    clr_err = 1'b0;
    checkOutput("clr_ovf", 32'(overflow), 32'h0);
    checkOutput("clr_drop", 32'(drop_cnt), 32'h0);

    // Full plus pop on the same cycle as done: capture dropped, next accepted.
    out_ready = 2'b01;
    for (int j = 0; j < 8; j++) begin
      done = 1'b1; result = 16'h0200 + 16'(j);
      applyStimulus();
    end
    checkOutput("fp_full_lvl", 32'(level), 32'd8);
    out_ready = 2'b11; result = 16'hAAAA;
    applyStimulus();
    checkOutput("fp_drop", 32'(drop_cnt), 32'd1);
    checkOutput("fp_level", 32'(level), 32'd7);
    checkOutput("fp_head", 32'(out_seq[15:8]), 32'd12);
    out_ready = 2'b01; result = 16'hBBBB;
    applyStimulus();
    done = 1'b0;
    checkOutput("fp_accept_drop", 32'(drop_cnt), 32'd1);
    checkOutput("fp_accept_lvl", 32'(level), 32'd8);
    out_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      checkOutput("fp_drain_seq", 32'(out_seq[15:8]), 32'(12 + k));
      checkOutput("fp_drain_res", 32'(out_result[31:16]),
                  (k < 7) ? 32'h0200 + 32'(k + 1) : 32'h0000BBBB);
      applyStimulus();
    end
    clr_err = 1'b1;
    applyStimulus();
    clr_err = 1'b0;

    // Consumer 1 disabled during 20 captures (seq 20..39).
    cons_en = 2'b01;
    for (int k = 0; k < 20; k++) begin
      done = 1'b1; result = 16'h0300 + 16'(k);
      applyStimulus();
      checkOutput("dis_valid1", 32'(out_valid[1]), 32'h0);
    end
    done = 1'b0;
    applyStimulus();
    checkOutput("dis_drop", 32'(drop_cnt), 32'h0);
    checkOutput("dis_ovf", 32'(overflow), 32'h0);
    cons_en = 2'b11;
    applyStimulus();
    checkOutput("reen_idle", 32'(out_valid), 32'h0);
    done = 1'b1; result = 16'h4444;
    applyStimulus();
    done = 1'b0;
    checkOutput("reen_valid", 32'(out_valid), 32'h3);
    checkOutput("reen_seq1", 32'(out_seq[15:8]), 32'd40);
    checkOutput("reen_res1", 32'(out_result[31:16]), 32'h4444);
    applyStimulus();
    checkOutput("reen_empty", 32'(out_valid), 32'h0);

    // Mid-stream reset with 5 pending entries.
    out_ready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      done = 1'b1; result = 16'h0500 + 16'(k);
      applyStimulus();
    end
    done = 1'b0;
    checkOutput("prerst_level", 32'(level), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'h0);
    checkOutput("async_level", 32'(level), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 2'b11; done = 1'b1; result = 16'hBEEF;
    applyStimulus();
    done = 1'b0;
    checkOutput("postrst_valid", 32'(out_valid), 32'h3);
    checkOutput("postrst_seq", 32'(out_seq[7:0]), 32'h0);
    checkOutput("postrst_res", 32'(out_result[15:0]), 32'hBEEF);
    applyStimulus();

    // clr_err coincident with a drop: the clear wins.
    out_ready = 2'b01;
    for (int k = 0; k < 8; k++) begin
      done = 1'b1; result = 16'h0600 + 16'(k);
      applyStimulus();
    end
    applyStimulus();
    checkOutput("cd_pre_ovf", 32'(overflow), 32'h1);
    checkOutput("cd_pre_drop", 32'(drop_cnt), 32'd1);
    clr_err = 1'b1;
    applyStimulus();
    clr_err = 1'b0; done = 1'b0;
    checkOutput("cd_ovf", 32'(overflow), 32'h0);
    checkOutput("cd_drop", 32'(drop_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
